// File: rtl/sign_pkg.sv
// -----------------------------------------------------------------------------
// sign_pkg
// Shared definitions for the sign_extend / sign_narrow_pack pair.
// HALF_W   : width of a narrowed halfword lane
// half_t   : halfword type used by both directions of the conversion
// HALF_MAX : largest positive halfword (saturation target for positive words)
// HALF_MIN : most negative halfword (saturation target for negative words)
// -----------------------------------------------------------------------------
package sign_pkg;

  localparam int HALF_W = 16;

  typedef logic [HALF_W-1:0] half_t;

  localparam half_t HALF_MAX = 16'h7FFF;
  localparam half_t HALF_MIN = 16'h8000;

endpackage

// File: rtl/sign_narrow.sv
// -----------------------------------------------------------------------------
// sign_narrow
// Combinational WIDTH -> 16-bit narrowing of one signed word, plus an overflow
// flag raised when the word does not fit in a signed halfword.
//
// Build option: NARROW_SAT_EN
//   defined   : overflowing words clamp to HALF_MAX / HALF_MIN
//   undefined : overflowing words are truncated to in_data[15:0]
// Overflow detection is identical in both builds.
//
// Ports
//   in_data  in   WIDTH  signed input word
//   narrow   out  16     narrowed halfword
//   ovf      out  1      word does not fit in 16 signed bits
// -----------------------------------------------------------------------------
module sign_narrow
  import sign_pkg::*;
#(
  parameter int WIDTH = 32
) (
  input  logic signed [WIDTH-1:0] in_data,
  output half_t                   narrow,
  output logic                    ovf
);

  // A word fits in a signed halfword exactly when bits [WIDTH-1:15] are all
  // copies of the same bit (all zeros or all ones).
  logic [WIDTH-HALF_W:0] upper;

  assign upper = in_data[WIDTH-1:HALF_W-1];
  assign ovf   = !((&upper) || !(|upper));

`ifdef NARROW_SAT_EN
  function automatic half_t saturate(input logic neg);
    return neg ? HALF_MIN : HALF_MAX;
  endfunction

  assign narrow = ovf ? saturate(in_data[WIDTH-1]) : in_data[HALF_W-1:0];
`else
  assign narrow = in_data[HALF_W-1:0];
`endif

endmodule

// File: rtl/sign_narrow_pack.sv
// -----------------------------------------------------------------------------
// sign_narrow_pack
// Streaming narrowing packer. Each accepted WIDTH-bit signed word is narrowed
// to a halfword and placed in the next lane of an accumulator; when the last
// lane is filled (or the word carries in_flush) the accumulator is moved into
// the output register together with the number of valid lanes. Lane 0 sits in
// bits [15:0]; lanes beyond out_count are zero.
//
// Build option: NARROW_SAT_EN (see sign_narrow) selects saturation instead of
// truncation for overflowing words.
//
// Ports
//   clk        in   1        clock, rising edge
//   rst_n      in   1        asynchronous active-low reset
//   in_valid   in   1        input word valid
//   in_ready   out  1        input accepted when in_valid && in_ready
//   in_data    in   WIDTH    signed input word
//   in_flush   in   1        with in_valid: this word closes the current pack
//   out_valid  out  1        packed word valid
//   out_ready  in   1        consumer accepts packed word
//   out_data   out  WIDTH    packed halfwords
//   out_count  out  COUNT_W  number of valid lanes (1..LANES)
//   clr_cnt    in   1        synchronous clear of ovf_count (wins over increment)
//   ovf_count  out  CNT_W    accepted overflowing words, saturating
// -----------------------------------------------------------------------------
module sign_narrow_pack
  import sign_pkg::*;
#(
  parameter  int WIDTH   = 32,
  parameter  int CNT_W   = 16,
  localparam int LANES   = WIDTH / HALF_W,
  localparam int COUNT_W = $clog2(LANES + 1)
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic                    in_valid,
  output logic                    in_ready,
  input  logic signed [WIDTH-1:0] in_data,
  input  logic                    in_flush,
  output logic                    out_valid,
  input  logic                    out_ready,
  output logic [WIDTH-1:0]        out_data,
  output logic [COUNT_W-1:0]      out_count,
  input  logic                    clr_cnt,
  output logic [CNT_W-1:0]        ovf_count
);

  localparam int IDX_W = $clog2(LANES);

  logic [WIDTH-1:0] acc;
  logic [IDX_W-1:0] idx;
  logic [WIDTH-1:0] acc_next;
  half_t            narrow;
  logic             ovf;
  logic             accept;
  logic             close_pack;

  sign_narrow #(
    .WIDTH (WIDTH)
  ) u_narrow (
    .in_data (in_data),
    .narrow  (narrow),
    .ovf     (ovf)
  );

  // The output register can take a new pack whenever it is empty or being
  // drained this cycle, so a full pack never stalls with out_ready high.
  assign in_ready   = !out_valid || out_ready;
  assign accept     = in_valid && in_ready;
  assign close_pack = (idx == IDX_W'(LANES - 1)) || in_flush;

  // Accumulator with the incoming halfword dropped into lane idx. Lanes above
  // idx are still zero because the accumulator is cleared after every pack.
  always_comb begin
    acc_next = acc;
    acc_next[idx*HALF_W +: HALF_W] = narrow;
  end

  // ---- accept stage: lane fill, pack hand-off, overflow counting ----
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      acc       <= '0;
      idx       <= '0;
      out_valid <= 1'b0;
      out_data  <= '0;
      out_count <= '0;
      ovf_count <= '0;
    end else begin
      if (out_valid && out_ready) begin
        out_valid <= 1'b0;
      end

      if (accept) begin
        if (close_pack) begin
          out_data  <= acc_next;
          out_count <= COUNT_W'(idx) + COUNT_W'(1);
          out_valid <= 1'b1;
          idx       <= '0;
          acc       <= '0;
        end else begin
          acc <= acc_next;
          idx <= idx + IDX_W'(1);
        end
      end

      if (clr_cnt) begin
        ovf_count <= '0;
      end else if (accept && ovf && (ovf_count != {CNT_W{1'b1}})) begin
        ovf_count <= ovf_count + CNT_W'(1);
      end
    end
  end

endmodule

// File: doc/sign_narrow_pack.md
# sign_narrow_pack

Streaming narrowing packer: the write-side counterpart of `sign_extend`. It accepts WIDTH-bit signed words, narrows each to a 16-bit halfword (saturating or wrapping), and packs LANES = WIDTH/16 halfwords into one WIDTH-bit output word. It sits between the datapath result bus and any 16-bit store or immediate path. Packed values round-trip through `sign_extend` unchanged whenever no overflow occurred.

## Interface
- WIDTH, 32, input/output word width; multiple of 16, ≥ 32; LANES = WIDTH/16
- CNT_W, 16, width of overflow counter
- CLK  in  1  clock, rising edge
- RST_N  in  1  reset, asynchronous, active-low
- IN_VALID  in  1  input word valid
- IN_READY  out  1  input accepted when IN_VALID && IN_READY
- IN_DATA  in  WIDTH  signed input word
- IN_FLUSH  in  1  qualified by IN_VALID; this word closes the current pack
- OUT_VALID  out  1  packed word valid
- OUT_READY  in  1  consumer accepts packed word
- OUT_DATA  out  WIDTH  packed halfwords, lane 0 in bits [15:0]
- OUT_COUNT  out  $clog2(LANES+1)  number of valid lanes in OUT_DATA (1..LANES)
- CLR_CNT  in  1  synchronous clear of OVF_COUNT
- OVF_COUNT  out  CNT_W  number of accepted words that did not fit in 16 bits; saturates at all-ones

## Operation
- Overflow for a word: IN_DATA[WIDTH-1:15] not all equal.
- Narrowed value: if no overflow, IN_DATA[15:0]; otherwise per Configuration.
- State: accumulator ACC (LANES×16 bits), lane index IDX (0..LANES-1), output register (OUT_DATA, OUT_COUNT, OUT_VALID).
- On accept: narrowed value written to ACC lane IDX.
  - If IDX == LANES-1 or IN_FLUSH: ACC (with the new lane) loads into the output register, OUT_COUNT = IDX+1, unused lanes zero, OUT_VALID = 1, IDX → 0, ACC cleared.
  - Else: IDX → IDX+1.
- IN_READY = !OUT_VALID || OUT_READY (combinational; independent of IN_VALID and IN_FLUSH).
- Output: OUT_VALID clears on OUT_READY unless a new pack loads in the same cycle. OUT_DATA and OUT_COUNT are held stable while OUT_VALID && !OUT_READY.
- OVF_COUNT increments by 1 on each accepted overflowing word (in both modes) and saturates at 2^CNT_W-1.
- CLR_CNT has priority: a simultaneous overflowing accept leaves OVF_COUNT at 0.
- IN_FLUSH without IN_VALID is ignored.
- Flush at IDX == LANES-1 behaves identically to normal completion.

## Timing
- Reset values: OUT_VALID=0, OUT_DATA=0, OUT_COUNT=0, OVF_COUNT=0, IDX=0, ACC=0. IN_READY reads 1 (follows !OUT_VALID).
- Reset asserted mid-pack discards ACC and the output register immediately, without waiting for a clock edge.
- Latency: OUT_VALID rises on the clock edge that accepts the completing or flushing word, so it is visible in the following cycle.
- Throughput: one input per cycle sustained with OUT_READY=1; one output per LANES inputs.
- OVF_COUNT updates on the accept edge.

## Configuration
- NARROW_SAT_EN defined: overflowing words saturate to 16'h7FFF (positive) or 16'h8000 (negative).
- NARROW_SAT_EN undefined: plain truncation to IN_DATA[15:0].
- Overflow detection and counting are identical in both modes.

## Structure
- Shared package `sign_pkg`:
  - HALF_W = 16
  - typedef half_t (logic [HALF_W-1:0])
  - constants HALF_MAX = 16'h7FFF, HALF_MIN = 16'h8000
  - `sign_extend` uses the same package.
- Sub-module `sign_narrow`: combinational WIDTH→16 narrowing plus overflow flag, NARROW_SAT_EN-aware, instantiated once.
- The top level holds IDX, ACC, the output register and the counter.

## Test plan
All scenarios use WIDTH=32.
- Inputs 256 then 14, OUT_READY=1 → one output 32'h000E_0100, OUT_COUNT=2, OVF_COUNT=0, OUT_VALID high for exactly 1 cycle.
- Inputs 32'hFFFF_FFFF then 32'h0001_0000 → with NARROW_SAT_EN: 32'h7FFF_FFFF; without: 32'h0000_FFFF. OVF_COUNT=1 in both modes.
- Input 32'hFFFF_8000 with IN_FLUSH=1 → 32'h0000_8000, OUT_COUNT=1, OVF_COUNT=0, IDX back to 0.
- OUT_READY=0, inputs 1, 2, 3 → OUT_DATA=32'h0002_0001 held stable, IN_READY=0 with word 3 pending. Raising OUT_READY for 1 cycle accepts word 3, no data lost.
- Accept 5, then pulse RST_N low, then inputs 7, 9 → single output 32'h0009_0007; all outputs 0 during reset.
- CLR_CNT=1 in the same cycle as accepting 32'h0004_0000 → OVF_COUNT=0. Force the counter to 16'hFFFF, then apply an overflowing input → OVF_COUNT stays 16'hFFFF.
